life_board: RTL and testbench

Sequential board engine for the Game of Life datapath: holds a WIDTH x HEIGHT cell board in registers and advances it a requested number of generations, computing one full row per clock. It feeds each cell's own state plus its eight neighbour bits into per-cell rule evaluators. It sits between the host load/readout logic and the rule cells, and reports live-cell population and stability after each run.

---
 rtl/life_pkg.sv | 21 ++
 rtl/life_rule.sv | 16 +
 rtl/life_board.sv | 202 ++++++++++++++++++++
 tb/tb_life_board.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life board engine.
package life_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] BIRTH_COUNT   = 4'd3;
  localparam logic [3:0] SURVIVE_COUNT = 4'd2;

  function automatic logic [3:0] count8(input logic [7:0] bits);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, bits[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/life_rule.sv
// Single-cell Game of Life rule: birth on exactly three live neighbours,
// survival on two or three.
module life_rule
  import life_pkg::*;
(
  input  logic       self_i,
  input  logic [7:0] nbr_i,
  output logic       next_o
);

  logic [3:0] count;

  assign count  = count8(nbr_i);
  assign next_o = (count == BIRTH_COUNT) | (self_i & (count == SURVIVE_COUNT));

endmodule

// File: rtl/life_board.sv
// Row-serial Game of Life board engine: one new row per clock, population and
// stability reported per generation. Define LIFE_WRAP_EN for a toroidal board.
module life_board
  import life_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                load_valid,
  output logic                                load_ready,
  input  logic [$clog2(HEIGHT)-1:0]           load_addr,
  input  logic [WIDTH-1:0]                    load_row,
  input  logic                                step_go,
  input  logic [7:0]                          gens,
  output logic                                busy,
  output logic                                done,
  input  logic                                rd_en,
  input  logic [$clog2(HEIGHT)-1:0]           rd_addr,
  output logic [WIDTH-1:0]                    rd_row,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   pop_count,
  output logic                                stable
);

  localparam int AW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH*HEIGHT+1);
  localparam logic [AW:0]   HEIGHT_C = HEIGHT[AW:0];
  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT-1);

  state_t          state_q, state_d;
  logic [AW-1:0]   r_q, r_d;
  logic [7:0]      gens_q, gens_d;
  logic [PW-1:0]   pop_acc_q, pop_acc_d;
  logic            chg_q, chg_d;
  logic [PW-1:0]   pop_count_q, pop_count_d;
  logic            stable_q, stable_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] board_q [HEIGHT];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rd_row_q;

  logic [WIDTH-1:0] up_row, cur_row, dn_row, new_row;
  logic [WIDTH+1:0] up_pad, cur_pad, dn_pad;
  logic [AW-1:0]    nxt_idx;
  logic             last_row;
  logic [PW-1:0]    row_pop;
  logic             row_chg;
  logic             load_ok, rd_ok;

  assign last_row = (r_q == LAST_ROW);
  assign nxt_idx  = last_row ? '0 : r_q + AW'(1);
  assign cur_row  = board_q[r_q];
  assign load_ok  = ({1'b0, load_addr} < HEIGHT_C);
  assign rd_ok    = ({1'b0, rd_addr} < HEIGHT_C);

`ifdef LIFE_WRAP_EN
  logic [WIDTH-1:0] row0_q;

  // Row 0 is overwritten first, so its old value is kept for the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row0_q <= '0;
    end else if (state_q == RUN && r_q == '0) begin
      row0_q <= cur_row;
    end
  end

  assign up_row  = (r_q == '0) ? board_q[HEIGHT-1] : prev_q;
  assign dn_row  = last_row ? row0_q : board_q[nxt_idx];
  assign up_pad  = {up_row[0], up_row, up_row[WIDTH-1]};
  assign cur_pad = {cur_row[0], cur_row, cur_row[WIDTH-1]};
  assign dn_pad  = {dn_row[0], dn_row, dn_row[WIDTH-1]};
`else
  assign up_row  = (r_q == '0) ? '0 : prev_q;
  assign dn_row  = last_row ? '0 : board_q[nxt_idx];
  assign up_pad  = {1'b0, up_row, 1'b0};
  assign cur_pad = {1'b0, cur_row, 1'b0};
  assign dn_pad  = {1'b0, dn_row, 1'b0};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      life_rule u_rule (
        .self_i (cur_pad[gi+1]),
        .nbr_i  ({up_pad[gi+2], up_pad[gi+1], up_pad[gi],
                  cur_pad[gi+2], cur_pad[gi],
                  dn_pad[gi+2], dn_pad[gi+1], dn_pad[gi]}),
        .next_o (new_row[gi])
      );
    end
  endgenerate

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row_pop = row_pop + PW'(new_row[i]);
    end
  end

  assign row_chg = |(new_row ^ cur_row);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    gens_d      = gens_q;
    pop_acc_d   = pop_acc_q;
    chg_d       = chg_q;
    pop_count_d = pop_count_q;
    stable_d    = stable_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (step_go) begin
          if (gens != 8'd0) begin
            state_d   = RUN;
            gens_d    = gens;
            r_d       = '0;
            pop_acc_d = '0;
            chg_d     = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (last_row) begin
          pop_count_d = pop_acc_q + row_pop;
          stable_d    = ~(chg_q | row_chg);
          pop_acc_d   = '0;
          chg_d       = 1'b0;
          r_d         = '0;
          gens_d      = gens_q - 8'd1;
          if (gens_q == 8'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          r_d       = r_q + AW'(1);
          pop_acc_d = pop_acc_q + row_pop;
          chg_d     = chg_q | row_chg;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      gens_q      <= '0;
      pop_acc_q   <= '0;
      chg_q       <= 1'b0;
      pop_count_q <= '0;
      stable_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      gens_q      <= gens_d;
      pop_acc_q   <= pop_acc_d;
      chg_q       <= chg_d;
      pop_count_q <= pop_count_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
    end
  end

  // Host writes only land in IDLE; in RUN the array is owned by the row sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HEIGHT; i++) begin
        board_q[i] <= '0;
      end
      prev_q   <= '0;
      rd_row_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (load_valid && load_ok) begin
          board_q[load_addr] <= load_row;
        end
      end else begin
        board_q[r_q] <= new_row;
        prev_q       <= cur_row;
      end
      if (rd_en) begin
        rd_row_q <= rd_ok ? board_q[rd_addr] : '0;
      end
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign rd_row     = rd_row_q;
  assign pop_count  = pop_count_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_life_board.sv
// Randomised bench for life_board against a whole-board generation model.
module tb_life_board;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = $clog2(H);
  localparam int PW = $clog2(W*H+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_row;
  logic          step_go;
  logic [7:0]    gens;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_row;
  logic [PW-1:0] pop_count;
  logic          stable;

  life_board #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_row   (load_row),
    .step_go    (step_go),
    .gens       (gens),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_row     (rd_row),
    .pop_count  (pop_count),
    .stable     (stable)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] mb [H];
  logic [W-1:0] wk [H];
  logic [W-1:0] nx [H];
  bit           m_busy, m_done, m_stable, m_fstab, rd_known;
  int           m_left, m_pop, m_fpop;
  logic [W-1:0] exp_rd;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int cell_at(int r, int c);
`ifdef LIFE_WRAP_EN
    r = (r + H) % H;
    c = (c + W) % W;
`else
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
`endif
    return int'(wk[r][c]);
  endfunction

  function automatic void life_gen();
    int n;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += cell_at(r + dr, c + dc);
        nx[r][c] = (n == 3) || (wk[r][c] && n == 2);
      end
    end
    m_fstab = 1;
    m_fpop  = 0;
    for (int r = 0; r < H; r++) begin
      if (nx[r] != wk[r]) m_fstab = 0;
      m_fpop += $countones(nx[r]);
    end
    wk = nx;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < H; r++) mb[r] = '0;
    m_busy = 0; m_done = 0; m_pop = 0; m_stable = 0; m_left = 0;
    rd_known = 1; exp_rd = '0;
  endfunction

  // One clock edge: model what the edge does given the inputs held across it.
  task automatic tick();
    logic          s_rst = rst, s_lv = load_valid, s_go = step_go, s_rd = rd_en;
    logic [AW-1:0] s_la = load_addr, s_ra = rd_addr;
    logic [W-1:0]  s_lr = load_row;
    logic [7:0]    s_g = gens;
    @(posedge clk);
    #1;
    m_done = 0;
    if (s_rst) begin
      model_reset();
      return;
    end
    if (s_rd) begin
      if (!m_busy) begin
        rd_known = 1;
        exp_rd = (int'(s_ra) < H) ? mb[s_ra] : '0;
      end else begin
        rd_known = 0;
      end
    end
    if (!m_busy) begin
      if (s_lv && int'(s_la) < H) mb[s_la] = s_lr;
      if (s_go) begin
        if (s_g == 8'd0) begin
          m_done = 1;
        end else begin
          m_busy = 1;
          m_left = int'(s_g) * H;
          wk = mb;
          for (int g = 0; g < int'(s_g); g++) life_gen();
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
        mb = wk; m_pop = m_fpop; m_stable = m_fstab;
      end
    end
  endtask

  always @(negedge clk) begin
    check("load_ready", 32'(load_ready), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (!m_busy) begin
      check("pop_count", 32'(pop_count), 32'(m_pop));
      check("stable", 32'(stable), 32'(m_stable));
    end
    if (rd_known) check("rd_row", 32'(rd_row), 32'(exp_rd));
  end

  task automatic clear_inputs();
    load_valid = 0; load_addr = '0; load_row = '0;
    step_go = 0; gens = '0; rd_en = 0; rd_addr = '0;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    load_valid = 1; load_addr = AW'(a); load_row = d;
    tick();
    load_valid = 0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < H; r++) load(r, '0);
  endtask

  task automatic read(input int a, output logic [W-1:0] d);
    rd_en = 1; rd_addr = AW'(a);
    tick();
    rd_en = 0;
    d = rd_row;
  endtask

  task automatic read_all();
    logic [W-1:0] d;
    for (int r = 0; r < H; r++) read(r, d);
  endtask

  // Start a run and wait for done; edges counts from the accepting edge.
  task automatic run_gens(input int g, input bit noise, output int edges);
    step_go = 1; gens = 8'(g);
    tick();
    step_go = 0; load_valid = 0;
    edges = 1;
    while (!done && edges < g * H + 8) begin
      if (noise) begin
        load_valid = 1'($urandom_range(0, 1));
        load_addr  = AW'($urandom);
        load_row   = W'($urandom);
        step_go    = 1'($urandom_range(0, 1));
        gens       = 8'($urandom_range(1, 3));
        rd_en      = 1'($urandom_range(0, 1));
        rd_addr    = AW'($urandom);
      end
      tick();
      edges++;
    end
    clear_inputs();
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: done not seen after %0d edges, expected within %0d", edges, g * H + 1);
    end
  endtask

  logic [W-1:0] d;
  int           edges;

  initial begin
    model_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    check("rst_pop", 32'(pop_count), 32'd0);
    rst = 0;
    read(0, d);
    check("rst_row0", 32'(d), 32'd0);

    // Blinker
    clear_board();
    load(3, 8'b00011100);
    run_gens(1, 0, edges);
    check("blink_latency", 32'(edges), 32'd9);
    check("blink_pop", 32'(pop_count), 32'd3);
    check("blink_stable", 32'(stable), 32'd0);
    for (int r = 2; r <= 4; r++) begin
      read(r, d);
      check("blink_row", 32'(d), 32'h08);
    end
    read(1, d);
    check("blink_row1", 32'(d), 32'h00);

    // Block still life
    clear_board();
    load(3, 8'b00011000);
    load(4, 8'b00011000);
    run_gens(5, 0, edges);
    check("block_pop", 32'(pop_count), 32'd4);
    check("block_stable", 32'(stable), 32'd1);
    read(4, d);
    check("block_row4", 32'(d), 32'h18);

    // Zero generations
    step_go = 1; gens = 8'd0;
    tick();
    step_go = 0;
    check("gens0_done", 32'(done), 32'd1);
    check("gens0_pop", 32'(pop_count), 32'd4);
    tick();
    check("gens0_done_clr", 32'(done), 32'd0);

    // Glider
    clear_board();
    load(0, 8'b00000010);
    load(1, 8'b00000100);
    load(2, 8'b00000111);
    run_gens(32, 0, edges);
`ifdef LIFE_WRAP_EN
    check("glider_pop", 32'(pop_count), 32'd5);
    read(0, d); check("glider_row0", 32'(d), 32'h02);
    read(1, d); check("glider_row1", 32'(d), 32'h04);
    read(2, d); check("glider_row2", 32'(d), 32'h07);
`endif
    read_all();

    // Load held during run is ignored; load + go in the same cycle is used
    load_valid = 1; load_addr = '0; load_row = 8'hFF;
    step_go = 1; gens = 8'd3;
    tick();
    step_go = 0;
    for (int k = 0; k < 3 * H + 2; k++) tick();
    clear_inputs();
    read_all();

    // Reset mid-run
    for (int r = 0; r < H; r++) load(r, W'($urandom));
    step_go = 1; gens = 8'd4;
    tick();
    step_go = 0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) tick();
    read_all();
    read(5, d);
    check("midrst_row5", 32'(d), 32'd0);
    load(3, 8'b00011100);
    run_gens(2, 0, edges);
    check("post_rst_pop", 32'(pop_count), 32'd3);

    // Random boards, generation counts and noise
    for (int it = 0; it < 30; it++) begin
      for (int r = 0; r < H - 1; r++) load(r, W'($urandom) & W'($urandom | $urandom));
      load_valid = 1; load_addr = AW'(H - 1); load_row = W'($urandom);
      if (it % 3 == 0) begin
        step_go = 1; gens = 8'(it % 4);
      end
      tick();
      clear_inputs();
      if (it % 3 != 0 || it % 4 == 0) begin
        if (it % 4 == 0 && it % 3 == 0) tick();
        run_gens($urandom_range(0, 5), 1'(it % 2), edges);
      end else begin
        while (busy) tick();
      end
      tick();
      read_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
